// File: rtl/balance_pkg.sv
// balance_pkg: shared types, FSM states and fixed-point constants for balance_pid
package balance_pkg;
  localparam int GAIN_FRAC_BITS = 4;
  typedef logic signed [7:0] gain_t;
  typedef logic signed [9:0] angle_t;
  typedef logic signed [25:0] acc_t;
  typedef enum logic [2:0] {IDLE, CAPTURE, PTERM, ITERM, DTERM, SAT} pid_state_e;
endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: 2-FF synchroniser plus rising-edge detector for an asynchronous strobe
// Ports: clk, rst_n (async active-low), i_async (raw strobe), o_pulse (one-cycle pulse per rising edge)
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);
  logic r_sync1, r_sync2, r_sync3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_sync1, r_sync2, r_sync3} <= '0;
    else {r_sync1, r_sync2, r_sync3} <= {i_async, r_sync1, r_sync2};
  assign o_pulse = r_sync2 & ~r_sync3;
endmodule

// File: rtl/balance_pid.sv
// balance_pid: multi-cycle PID balance controller with one shared multiplier and saturated output
// Ports: clk, reset_n (async active-low), AngleStrobe (async update strobe), Angle (signed 10-bit),
//        Enable (low = idle and cleared), MotorCmd (signed 10-bit), CmdValid (one-cycle pulse),
//        Saturated (last command clamped), Overrun (sticky dropped strobe), Busy (FSM not idle)
// Build option: define PID_INTEGRAL_EN to include the integral term (ITERM state, integrator, I_LIMIT clamp).
module balance_pid
  import balance_pkg::*;
#(
  parameter angle_t SETPOINT  = 10'sd0,
  parameter gain_t  KP        = 8'sd16,
  parameter gain_t  KI        = 8'sd0,
  parameter gain_t  KD        = 8'sd0,
  parameter int     I_LIMIT   = 2000,
  parameter int     OUT_LIMIT = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       AngleStrobe,
  input  logic [9:0] Angle,
  input  logic       Enable,
  output logic [9:0] MotorCmd,
  output logic       CmdValid,
  output logic       Saturated,
  output logic       Overrun,
  output logic       Busy
);
  if (I_LIMIT <= 0 || I_LIMIT >= 32768 || OUT_LIMIT <= 0 || OUT_LIMIT > 511) begin : g_bad_limits
    $error("balance_pid: I_LIMIT or OUT_LIMIT out of range");
  end
  localparam logic signed [21:0] OMAX = 22'(OUT_LIMIT);
  localparam logic signed [21:0] OMIN = -OMAX;
  pid_state_e r_state, w_next;
  logic w_edge, w_busy, w_capture, w_mac, w_sat, w_clip;
  logic signed [10:0] w_e, r_e, r_eprev;
  logic signed [11:0] w_d, r_d;
  acc_t r_acc;
  gain_t w_gain;
  logic signed [15:0] w_term;
  logic signed [23:0] w_prod;
  logic signed [21:0] w_shift;
  logic signed [9:0] w_cmd, r_cmd;
  logic r_valid, r_sat, r_ovr, r_first;
  strobe_sync u_sync (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_async (AngleStrobe),
    .o_pulse (w_edge)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (!Enable) w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = w_edge ? CAPTURE : IDLE;
        CAPTURE: w_next = PTERM;
`ifdef PID_INTEGRAL_EN
        PTERM:   w_next = ITERM;
        ITERM:   w_next = DTERM;
`else
        PTERM:   w_next = DTERM;
`endif
        DTERM:   w_next = SAT;
        default: w_next = IDLE;
      endcase
  end
  always_comb begin
    w_busy    = r_state != IDLE;
    w_capture = r_state == CAPTURE;
    w_mac     = r_state inside {PTERM, ITERM, DTERM};
    w_sat     = r_state == SAT;
  end
  assign w_e = $signed({SETPOINT[9], SETPOINT}) - $signed({Angle[9], Angle});
  // the derivative of the first sample after enable has no valid predecessor
  assign w_d = r_first ? 12'sd0 : $signed({w_e[10], w_e}) - $signed({r_eprev[10], r_eprev});
`ifdef PID_INTEGRAL_EN
  localparam logic signed [16:0] IMAX = 17'(I_LIMIT);
  localparam logic signed [16:0] IMIN = -IMAX;
  logic signed [15:0] r_integ, w_isat;
  logic signed [16:0] w_isum;
  assign w_isum = $signed({r_integ[15], r_integ}) + $signed({{6{w_e[10]}}, w_e});
  assign w_isat = w_isum > IMAX ? IMAX[15:0] : w_isum < IMIN ? IMIN[15:0] : w_isum[15:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_integ <= '0;
    else if (!Enable) r_integ <= '0;
    else if (w_capture) r_integ <= w_isat;
  assign w_gain = r_state == PTERM ? KP : r_state == ITERM ? KI : KD;
  assign w_term = r_state == PTERM ? $signed({{5{r_e[10]}}, r_e}) :
                  r_state == ITERM ? r_integ : $signed({{4{r_d[11]}}, r_d});
`else
  if (KI != 0) begin : g_ki_ignored
    $warning("balance_pid: KI has no effect without PID_INTEGRAL_EN");
  end
  assign w_gain = r_state == PTERM ? KP : KD;
  assign w_term = r_state == PTERM ? $signed({{5{r_e[10]}}, r_e}) : $signed({{4{r_d[11]}}, r_d});
`endif
  assign w_prod = w_gain * w_term;
  // dropping the Q4.4 fraction bits of a signed value is a floor division by 16
  assign w_shift = r_acc[25:GAIN_FRAC_BITS];
  assign w_clip  = w_shift > OMAX || w_shift < OMIN;
  assign w_cmd   = w_shift > OMAX ? OMAX[9:0] : w_shift < OMIN ? OMIN[9:0] : w_shift[9:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_e     <= '0;
      r_d     <= '0;
      r_eprev <= '0;
      r_acc   <= '0;
      r_cmd   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      r_ovr   <= 1'b0;
      r_first <= 1'b1;
    end else if (!Enable) begin
      r_eprev <= '0;
      r_cmd   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      r_ovr   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_valid <= w_sat;
      if (w_edge && w_busy) r_ovr <= 1'b1;
      if (w_capture) begin
        r_e     <= w_e;
        r_d     <= w_d;
        r_eprev <= w_e;
        r_first <= 1'b0;
        r_acc   <= '0;
      end
      if (w_mac) r_acc <= r_acc + $signed({{2{w_prod[23]}}, w_prod});
      if (w_sat) begin
        r_cmd <= w_cmd;
        r_sat <= w_clip;
      end
    end
  assign MotorCmd  = r_cmd;
  assign CmdValid  = r_valid;
  assign Saturated = r_sat;
  assign Overrun   = r_ovr;
  assign Busy      = w_busy;
endmodule

// File: tb/tb_balance_pid.sv
// tb_balance_pid: directed self-checking bench for balance_pid using several gain configurations
module tb_balance_pid;
`ifdef PID_INTEGRAL_EN
  localparam int LAT = 5, D_OFS = 3;
`else
  localparam int LAT = 4, D_OFS = 2;
`endif
  logic clk = 1'b0, reset_n = 1'b0, strobe = 1'b0, enable = 1'b0;
  logic signed [9:0] angle = '0;
  logic signed [9:0] p_cmd, c_cmd, d_cmd;
  logic p_cv, p_sat, p_ovr, p_busy;
  logic c_cv, c_sat, c_ovr, c_busy;
  logic d_cv, d_sat, d_ovr, d_busy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  balance_pid #(.KP(8'sd16)) dut_p (
    .clk(clk), .reset_n(reset_n), .AngleStrobe(strobe), .Angle(angle), .Enable(enable),
    .MotorCmd(p_cmd), .CmdValid(p_cv), .Saturated(p_sat), .Overrun(p_ovr), .Busy(p_busy));
  balance_pid #(.KP(8'sd32)) dut_c (
    .clk(clk), .reset_n(reset_n), .AngleStrobe(strobe), .Angle(angle), .Enable(enable),
    .MotorCmd(c_cmd), .CmdValid(c_cv), .Saturated(c_sat), .Overrun(c_ovr), .Busy(c_busy));
  balance_pid #(.KP(8'sd0), .KD(8'sd16)) dut_d (
    .clk(clk), .reset_n(reset_n), .AngleStrobe(strobe), .Angle(angle), .Enable(enable),
    .MotorCmd(d_cmd), .CmdValid(d_cv), .Saturated(d_sat), .Overrun(d_ovr), .Busy(d_busy));
`ifdef PID_INTEGRAL_EN
  logic signed [9:0] i_cmd;
  logic i_cv, i_sat, i_ovr, i_busy;
  balance_pid #(.KP(8'sd0), .KI(8'sd16), .I_LIMIT(25)) dut_i (
    .clk(clk), .reset_n(reset_n), .AngleStrobe(strobe), .Angle(angle), .Enable(enable),
    .MotorCmd(i_cmd), .CmdValid(i_cv), .Saturated(i_sat), .Overrun(i_ovr), .Busy(i_busy));
`endif
  task automatic clear_ctrl();
    @(negedge clk); enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask
  // raise the strobe and return at the first negedge with Busy high (CAPTURE cycle)
  task automatic launch(input logic signed [9:0] a, output bit ok);
    @(negedge clk);
    angle = a; strobe = 1'b1; ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (p_busy) ok = 1'b1;
    end
    strobe = 1'b0;
  endtask
  // cv_at: negedges from CAPTURE to the CmdValid pulse (-1 if none); pulses: CmdValid cycles seen
  task automatic fire(input logic signed [9:0] a, output int cv_at, output int pulses);
    bit ok;
    launch(a, ok);
    cv_at = -1; pulses = 0;
    if (ok)
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if (p_cv) begin
          pulses++;
          if (cv_at < 0) cv_at = i;
        end
      end
  endtask
  task automatic test_reset();
    checks += 5;
    if (p_cmd !== 10'sd0) begin failures++; $display("FAIL reset_cmd got=%0d exp=0", p_cmd); end
    if (p_cv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", p_cv); end
    if (p_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", p_sat); end
    if (p_ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", p_ovr); end
    if (p_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", p_busy); end
  endtask
  task automatic test_proportional();
    int cv_at, pulses;
    clear_ctrl();
    fire(-10'sd50, cv_at, pulses);
    checks += 6;
    if (cv_at != LAT) begin failures++; $display("FAIL prop_latency got=%0d exp=%0d", cv_at, LAT); end
    if (pulses != 1) begin failures++; $display("FAIL prop_pulses got=%0d exp=1", pulses); end
    if (p_cmd !== 10'sd50) begin failures++; $display("FAIL prop_cmd got=%0d exp=50", p_cmd); end
    if (p_sat !== 1'b0) begin failures++; $display("FAIL prop_sat got=%b exp=0", p_sat); end
    if (c_cmd !== 10'sd100) begin failures++; $display("FAIL prop_kp2_cmd got=%0d exp=100", c_cmd); end
    if (d_cmd !== 10'sd0) begin failures++; $display("FAIL prop_d_first got=%0d exp=0", d_cmd); end
  endtask
  task automatic test_clamp();
    int cv_at, pulses;
    fire(-10'sd400, cv_at, pulses);
    checks += 4;
    if (c_cmd !== 10'sd500) begin failures++; $display("FAIL clamp_pos_cmd got=%0d exp=500", c_cmd); end
    if (c_sat !== 1'b1) begin failures++; $display("FAIL clamp_pos_sat got=%b exp=1", c_sat); end
    if (p_cmd !== 10'sd400) begin failures++; $display("FAIL clamp_unclipped got=%0d exp=400", p_cmd); end
    if (p_sat !== 1'b0) begin failures++; $display("FAIL clamp_unclipped_sat got=%b exp=0", p_sat); end
    fire(10'sd400, cv_at, pulses);
    checks += 3;
    if (c_cmd !== -10'sd500) begin failures++; $display("FAIL clamp_neg_cmd got=%0d exp=-500", c_cmd); end
    if (c_sat !== 1'b1) begin failures++; $display("FAIL clamp_neg_sat got=%b exp=1", c_sat); end
    if (p_cmd !== -10'sd400) begin failures++; $display("FAIL clamp_neg_unclipped got=%0d exp=-400", p_cmd); end
  endtask
  task automatic test_derivative();
    logic signed [9:0] angs [3] = '{10'sd0, -10'sd10, -10'sd3};
    logic signed [9:0] exps [3] = '{10'sd0, 10'sd10, -10'sd7};
    int cv_at, pulses;
    clear_ctrl();
    for (int k = 0; k < 3; k++) begin
      fire(angs[k], cv_at, pulses);
      checks++;
      if (d_cmd !== exps[k]) begin
        failures++; $display("FAIL deriv_%0d got=%0d exp=%0d", k, d_cmd, exps[k]);
      end
    end
  endtask
`ifdef PID_INTEGRAL_EN
  task automatic test_integral();
    logic signed [9:0] exps [4] = '{10'sd10, 10'sd20, 10'sd25, 10'sd25};
    int cv_at, pulses;
    clear_ctrl();
    for (int k = 0; k < 4; k++) begin
      fire(-10'sd10, cv_at, pulses);
      checks++;
      if (i_cmd !== exps[k]) begin
        failures++; $display("FAIL integ_%0d got=%0d exp=%0d", k, i_cmd, exps[k]);
      end
    end
  endtask
`endif
  task automatic test_overrun();
    int pulses = 0;
    clear_ctrl();
    angle = -10'sd50;
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (2) @(negedge clk);
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (p_cv) pulses++;
    end
    checks += 3;
    if (pulses != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", pulses); end
    if (p_ovr !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", p_ovr); end
    if (p_cmd !== 10'sd50) begin failures++; $display("FAIL ovr_cmd got=%0d exp=50", p_cmd); end
    enable = 1'b0;
    @(negedge clk);
    checks += 2;
    if (p_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", p_ovr); end
    if (p_cmd !== 10'sd0) begin failures++; $display("FAIL ovr_cmd_clear got=%0d exp=0", p_cmd); end
    enable = 1'b1;
  endtask
  task automatic test_reset_abort();
    int cv_at, pulses = 0;
    bit ok;
    clear_ctrl();
    fire(-10'sd50, cv_at, pulses);
    launch(-10'sd60, ok);
    repeat (D_OFS) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (!ok) begin failures++; $display("FAIL rst_launch got=timeout exp=busy"); end
    if (p_cmd !== 10'sd0) begin failures++; $display("FAIL rst_cmd got=%0d exp=0", p_cmd); end
    if (p_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", p_busy); end
    if (p_cv !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", p_cv); end
    @(negedge clk); reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p_cv) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL rst_no_valid got=%0d exp=0", pulses); end
    fire(-10'sd50, cv_at, pulses);
    launch(-10'sd20, ok);
    @(negedge clk);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p_cv) pulses++;
    end
    checks += 3;
    if (pulses != 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", pulses); end
    if (p_cmd !== 10'sd0) begin failures++; $display("FAIL abort_cmd got=%0d exp=0", p_cmd); end
    if (p_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", p_busy); end
    enable = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    enable = 1'b1;
    test_proportional();
    test_clamp();
    test_derivative();
`ifdef PID_INTEGRAL_EN
    test_integral();
`endif
    test_overrun();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
